// File: rtl/his_pkg.sv
// Shared types, defaults and helpers for the SiFH histogram builder and its
// downstream peak-finder.
package his_pkg;

  localparam int unsigned DEF_NB           = 8;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_PIXELS       = 4;
  localparam int unsigned DEF_BINS_PER_HIS = 256;
  localparam int unsigned DEF_ACQ_NUM      = 4;
  localparam int unsigned DROP_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } his_state_t;

  // Bits needed to index v entries; never less than 1 so ports stay legal.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Increment saturating at 2^w - 1 (w < 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/his_rmw_pipe.sv
// Two-stage read/increment/write datapath with forwarding from the two most
// recent writes; also carries the zero writes issued during region clear.
module his_rmw_pipe
  import his_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_acc,
  input  logic [AW-1:0]    i_addr,
  input  logic [CNT_W-1:0] i_rdata,
  input  logic             i_clr_wr,
  input  logic [AW-1:0]    i_clr_addr,
  output logic             o_wen,
  output logic [AW-1:0]    o_waddr,
  output logic [CNT_W-1:0] o_wdata,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1_vld;
  logic [AW-1:0]    r_s1_addr;
  logic             r_wen, r_wen_d;
  logic [AW-1:0]    r_waddr, r_waddr_d;
  logic [CNT_W-1:0] r_wdata, r_wdata_d;
  logic [CNT_W-1:0] w_old;
  logic [CNT_W-1:0] w_new;

  // RAM read misses the write in the read cycle and the one after it, so the
  // newest of those two wins over ram_rdata.
  always_comb begin
    w_old = i_rdata;
    if (r_wen_d && (r_waddr_d == r_s1_addr)) w_old = r_wdata_d;
    if (r_wen && (r_waddr == r_s1_addr))     w_old = r_wdata;
  end

  assign w_new = CNT_W'(sat_inc(32'(w_old), CNT_W));
  assign o_sat = r_s1_vld && (w_old == CNT_MAX);

  always_ff @(posedge clk) begin
    if (res) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wen_d   <= 1'b0;
      r_waddr_d <= '0;
      r_wdata_d <= '0;
    end else begin
      r_s1_vld  <= i_acc;
      r_s1_addr <= i_addr;
      r_wen_d   <= r_wen;
      r_waddr_d <= r_waddr;
      r_wdata_d <= r_wdata;
      if (r_s1_vld) begin
        r_wen   <= 1'b1;
        r_waddr <= r_s1_addr;
        r_wdata <= w_new;
      end else if (i_clr_wr) begin
        r_wen   <= 1'b1;
        r_waddr <= i_clr_addr;
        r_wdata <= '0;
      end else begin
        r_wen   <= 1'b0;
      end
    end
  end

  assign o_wen   = r_wen;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/his_builder_rmw.sv
// Histogram builder: control FSM, clear sweep, frame and drop counting around
// the pipelined saturating read-modify-write datapath.
module his_builder_rmw
  import his_pkg::*;
#(
  parameter  int unsigned NB           = DEF_NB,
  parameter  int unsigned CNT_W        = DEF_CNT_W,
  parameter  int unsigned PIXELS       = DEF_PIXELS,
  parameter  int unsigned BINS_PER_HIS = DEF_BINS_PER_HIS,
  parameter  int unsigned ACQ_NUM      = DEF_ACQ_NUM,
  localparam int unsigned PIX_W        = clog2_f(PIXELS),
  localparam int unsigned RAM_ADDR     = clog2_f(PIXELS * BINS_PER_HIS)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic                clear_en,
  input  logic                evt_valid,
  input  logic [PIX_W-1:0]    evt_pixel,
  input  logic [NB-1:0]       evt_bin,
  output logic                evt_ready,
  input  logic                frame_end,
  output logic                ram_ren,
  output logic [RAM_ADDR-1:0] ram_raddr,
  input  logic [CNT_W-1:0]    ram_rdata,
  output logic                ram_wen,
  output logic [RAM_ADDR-1:0] ram_waddr,
  output logic [CNT_W-1:0]    ram_wdata,
  output logic                busy,
  output logic                done,
  output logic                sat_flag,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int unsigned N_WORDS = PIXELS * BINS_PER_HIS;
  localparam int unsigned ACQ_W   = clog2_f(ACQ_NUM + 1);

  his_state_t          r_state, w_next;
  logic [RAM_ADDR-1:0] r_clr_addr;
  logic [ACQ_W-1:0]    r_acq;
  logic                r_drain;
  logic [DROP_W-1:0]   r_drop;
  logic                r_sat;

  logic                w_in_range;
  logic                w_evt;
  logic                w_acc;
  logic                w_drop;
  logic                w_last_frame;
  logic                w_clr_last;
  logic                w_clr_wr;
  logic [RAM_ADDR-1:0] w_clr_addr;
  logic [RAM_ADDR-1:0] w_addr;
  logic                w_sat;

  assign w_in_range   = (32'(evt_bin) < BINS_PER_HIS) && (32'(evt_pixel) < PIXELS);
  assign w_evt        = evt_ready && evt_valid;
  assign w_acc        = w_evt && w_in_range;
  assign w_drop       = w_evt && !w_in_range;
  assign w_addr       = RAM_ADDR'(32'(evt_pixel) * BINS_PER_HIS + 32'(evt_bin));
  assign w_last_frame = (r_state == ST_ACCUM) && frame_end &&
                        (r_acq == ACQ_W'(ACQ_NUM - 1));
  assign w_clr_last   = (r_clr_addr == RAM_ADDR'(N_WORDS - 1));
  // The write for address 0 is registered from IDLE, so each CLEAR cycle
  // shows r_clr_addr on the write port and queues the next one.
  assign w_clr_addr   = (r_state == ST_CLEAR) ? r_clr_addr + RAM_ADDR'(1) : '0;

  always_ff @(posedge clk) begin
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_clr_wr  = 1'b0;
    evt_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_clr_wr = clear_en;
          w_next   = clear_en ? ST_CLEAR : ST_ACCUM;
        end
      end
      ST_CLEAR: begin
        if (w_clr_last) w_next = ST_ACCUM;
        else            w_clr_wr = 1'b1;
      end
      ST_ACCUM: begin
        evt_ready = 1'b1;
        if (w_last_frame) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_clr_addr <= '0;
      r_acq      <= '0;
      r_drain    <= 1'b0;
      r_drop     <= '0;
      r_sat      <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_clr_addr <= '0;
      r_acq      <= '0;
      r_drain    <= 1'b0;
      r_drop     <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + RAM_ADDR'(1);
      if ((r_state == ST_ACCUM) && frame_end) r_acq <= r_acq + ACQ_W'(1);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
      if (w_sat) r_sat <= 1'b1;
      r_drain <= (r_state == ST_DRAIN) && !r_drain;
    end
  end

  his_rmw_pipe #(
    .CNT_W (CNT_W),
    .AW    (RAM_ADDR)
  ) u_pipe (
    .clk        (clk),
    .res        (res),
    .i_acc      (w_acc),
    .i_addr     (w_addr),
    .i_rdata    (ram_rdata),
    .i_clr_wr   (w_clr_wr),
    .i_clr_addr (w_clr_addr),
    .o_wen      (ram_wen),
    .o_waddr    (ram_waddr),
    .o_wdata    (ram_wdata),
    .o_sat      (w_sat)
  );

  assign ram_ren   = w_acc;
  assign ram_raddr = w_acc ? w_addr : '0;
  assign sat_flag  = r_sat;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_his_builder_rmw.sv
// Bench for his_builder_rmw: behavioural RAM plus an array histogram model
// fed by the accepted events.
module tb_his_builder_rmw;

  localparam int unsigned NB     = 9;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PIXELS = 3;
  localparam int unsigned BINS   = 256;
  localparam int unsigned ACQ    = 4;
  localparam int unsigned NW     = PIXELS * BINS;
  localparam int unsigned AW     = 10;
  localparam int unsigned PW     = 2;
  localparam int          CMAX   = 15;

  logic              clk = 1'b0;
  logic              res, start, clear_en, evt_valid, frame_end;
  logic [PW-1:0]     evt_pixel;
  logic [NB-1:0]     evt_bin;
  logic              evt_ready, ram_ren, ram_wen, busy, done, sat_flag;
  logic [AW-1:0]     ram_raddr, ram_waddr;
  logic [CNT_W-1:0]  ram_rdata, ram_wdata;
  logic [15:0]       drop_cnt;

  his_builder_rmw #(
    .NB           (NB),
    .CNT_W        (CNT_W),
    .PIXELS       (PIXELS),
    .BINS_PER_HIS (BINS),
    .ACQ_NUM      (ACQ)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .clear_en  (clear_en),
    .evt_valid (evt_valid),
    .evt_pixel (evt_pixel),
    .evt_bin   (evt_bin),
    .evt_ready (evt_ready),
    .frame_end (frame_end),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Dual-port RAM returning old data on read-during-write.
  logic [CNT_W-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end

  int n_wr = 0, n_wr_nz = 0;
  always @(negedge clk) begin
    if (ram_wen) begin
      n_wr++;
      if (ram_wdata != '0) n_wr_nz++;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  int exp_mem [NW];
  int drop_exp = 0;
  bit sat_exp  = 0;
  int acc_wr   = 0;

  // Called at a falling edge; drives one cycle and advances to the next falling edge.
  task automatic drive(input bit v, input int px, input int bn, input bit fe, input bit acc);
    bit inr;
    int a;
    evt_valid = v;
    evt_pixel = PW'(px);
    evt_bin   = NB'(bn);
    frame_end = fe;
    inr = (px < int'(PIXELS)) && (bn < int'(BINS));
    a   = px * int'(BINS) + bn;
    #1;
    check("ready", evt_ready, acc);
    if (acc) begin
      check("ren", ram_ren, v && inr);
      if (v && inr) check("raddr", ram_raddr, a);
      if (v) begin
        if (!inr) drop_exp++;
        else begin
          acc_wr++;
          if (exp_mem[a] >= CMAX) sat_exp = 1;
          else exp_mem[a] = exp_mem[a] + 1;
        end
      end
    end
    @(negedge clk);
    evt_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, wclr, nz0, w0, px, bn;
    res = 1'b1; start = 1'b0; clear_en = 1'b0; evt_valid = 1'b0;
    evt_pixel = '0; evt_bin = '0; frame_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", evt_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_wen", ram_wen, 0);
    check("rst_ren", ram_ren, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_wdata", ram_wdata, 0);
    res = 1'b0;
    @(negedge clk);

    // frame_end in IDLE must not advance the acquisition count
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    check("idle_busy", busy, 0);

    // Clear build
    nz0 = n_wr_nz; w0 = n_wr;
    start = 1'b1; clear_en = 1'b1;
    #1;
    check("clr_wen_early", ram_wen, 0);
    @(negedge clk);
    start = 1'b0; clear_en = 1'b0;
    check("clr_first_wen", ram_wen, 1);
    check("clr_first_addr", ram_waddr, 0);
    check("clr_busy", busy, 1);
    k = 1;
    while (!evt_ready && k < 2000) begin
      frame_end = (k % 100 == 0);
      @(negedge clk);
      k++;
    end
    frame_end = 1'b0;
    check("clr_len", k, NW + 1);
    check("clr_writes", n_wr - w0, NW);
    check("clr_nonzero", n_wr_nz - nz0, 0);
    wclr = n_wr;
    for (int i = 0; i < int'(NW); i++) exp_mem[i] = 0;
    drop_exp = 0; sat_exp = 0; acc_wr = 0;

    // Single event (2,5) -> address 517 written with 1 two cycles later
    drive(1, 2, 5, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("single_wen", ram_wen, 1);
    check("single_waddr", ram_waddr, 517);
    check("single_wdata", ram_wdata, exp_mem[517]);

    // Back-to-back, then spacing 2 and 3, all to (0,7)
    for (int i = 0; i < 10; i++) drive(1, 0, 7, 0, 1);
    for (int i = 0; i < 2; i++) begin drive(1, 0, 7, 0, 1); drive(0, 0, 0, 0, 1); end
    for (int i = 0; i < 2; i++) begin drive(1, 0, 7, 0, 1); drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1); end
    repeat (3) drive(0, 0, 0, 0, 1);
    check("b2b_count", mem[7], exp_mem[7]);
    check("b2b_sat", sat_flag, sat_exp);

    // Random traffic over a few hot bins with occasional out-of-range events
    for (int i = 0; i < 400; i++) begin
      px = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      bn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 5));
      drive($urandom_range(0, 3) != 0, px, bn, (i == 100) || (i == 200) || (i == 300), 1);
    end
    repeat (3) drive(0, 0, 0, 0, 1);
    check("rnd_sat", sat_flag, sat_exp);
    check("rnd_drop", drop_cnt, drop_exp);
    check("rnd_writes", n_wr - wclr, acc_wr);

    // Saturation on (1,200)
    for (int i = 0; i < 20; i++) drive(1, 1, 200, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);
    check("sat_bin", mem[456], exp_mem[456]);
    check("sat_flag", sat_flag, 1);

    // Out-of-range bin and pixel
    drive(1, 0, 300, 0, 1);
    drive(1, 3, 5, 0, 1);
    check("oor_drop", drop_cnt, drop_exp);

    // Fourth frame_end with a simultaneous event (1,9)
    drive(1, 1, 9, 1, 1);
    check("frm_ready_drop", evt_ready, 0);
    check("frm_busy", busy, 1);
    d = 1;
    while (!done && d < 20) begin
      @(negedge clk);
      d++;
    end
    check("done_latency", d, 3);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("done_idle", busy, 0);
    check("last_evt", mem[265], exp_mem[265]);
    check("final_writes", n_wr - wclr, acc_wr);
    for (int i = 0; i < int'(NW); i++) check("mem", mem[i], exp_mem[i]);

    // New build without clear, then reset mid-stream
    start = 1'b1;
    drive(0, 0, 0, 0, 0);
    start = 1'b0;
    check("nb_sat_clr", sat_flag, 0);
    check("nb_drop_clr", drop_cnt, 0);
    drop_exp = 0;
    for (int i = 0; i < 20; i++) begin
      px = int'($urandom_range(0, 2));
      drive(1, px, (i % 5 == 0) ? 400 : int'($urandom_range(0, 3)), 0, 1);
    end
    check("nb_drop", drop_cnt, drop_exp);
    res = 1'b1; evt_valid = 1'b1; evt_pixel = '0; evt_bin = NB'(1);
    @(negedge clk);
    check("mid_rst_wen", ram_wen, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_ready", evt_ready, 0);
    check("mid_rst_sat", sat_flag, 0);
    res = 1'b0; evt_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
